// File: rtl/pll_rst_seq_pkg.sv
// rtl/pll_rst_seq_pkg.sv - shared state encoding and constant helpers for the PLL reset sequencer
package pll_rst_seq_pkg;

   typedef enum logic [2:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// rtl/pll_rst_seq_sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic d_out
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset pulse, lock qualification, retry and design reset sequencer
module pll_rst_seq
   import pll_rst_seq_pkg::*;
#(
   parameter int RST_HOLD_CYC     = 1000,
   parameter int LOCK_TIMEOUT_CYC = 500000,
   parameter int LOCK_STABLE_CYC  = 5000,
   parameter int MAX_RETRY        = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       design_rst,
   output logic       locked,
   output logic       fail,
   output logic [7:0] retry_cnt,
   output logic [7:0] lock_loss_cnt,
   output logic [2:0] state_o
);

   localparam int TW = $clog2(max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC) + 1);

   localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
   // The WAIT_LOCK cycle that first sees lock counts as stable cycle one,
   // so STABLE itself only needs LOCK_STABLE_CYC-1 more lock-high cycles.
   localparam logic [TW-1:0] STABLE_LAST  = TW'((LOCK_STABLE_CYC >= 2) ? LOCK_STABLE_CYC - 2 : 0);
   localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRY);

   logic lock_s;

   sync_2ff u_lock_sync (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .d_in  (pll_lock),
      .d_out (lock_s)
   );

   state_t          state_d, state_q;
   logic [TW-1:0]   timer_d, timer_q;
   logic [7:0]      retry_d, retry_q;
   logic [7:0]      loss_d, loss_q;
   logic            pll_rst_d, pll_rst_q;
   logic            design_rst_d, design_rst_q;
   logic            locked_d, locked_q;
   logic            fail_d, fail_q;
   logic [7:0]      retry_next;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      retry_d    = retry_q;
      loss_d     = loss_q;
      retry_next = retry_q + 8'd1;

      case (state_q)
         RESET: begin
            if (timer_q == HOLD_LAST) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
               retry_d = retry_next;
               state_d = (retry_next == RETRY_LIMIT) ? FAIL : RESET;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STABLE_LAST) begin
               state_d = RUN;
               timer_d = '0;
               retry_d = 8'd0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = RESET;
               timer_d = '0;
               if (loss_q != 8'd255) loss_d = loss_q + 8'd1;
            end
         end
         FAIL: begin
            timer_d = '0;
         end
         default: begin
            state_d = RESET;
            timer_d = '0;
         end
      endcase

      if (relock_req) begin
         state_d = RESET;
         timer_d = '0;
         retry_d = 8'd0;
      end

      // Outputs are decoded from the next state so they line up with state_q.
      pll_rst_d    = (state_d == RESET) || (state_d == FAIL);
      design_rst_d = (state_d != RUN);
      locked_d     = (state_d == RUN);
      fail_d       = (state_d == FAIL);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= RESET;
         timer_q      <= '0;
         retry_q      <= 8'd0;
         loss_q       <= 8'd0;
         pll_rst_q    <= 1'b1;
         design_rst_q <= 1'b1;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         pll_rst_q    <= pll_rst_d;
         design_rst_q <= design_rst_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign design_rst    = design_rst_q;
   assign locked        = locked_q;
   assign fail          = fail_q;
   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = loss_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - directed bench for the PLL reset sequencer
module tb_pll_rst_seq;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       pll_lock;
   logic       relock_req;
   logic       pll_rst;
   logic       design_rst;
   logic       locked;
   logic       fail;
   logic [7:0] retry_cnt;
   logic [7:0] lock_loss_cnt;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_STABLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_FAIL   = 3'd4;

   pll_rst_seq #(
      .RST_HOLD_CYC     (4),
      .LOCK_TIMEOUT_CYC (20),
      .LOCK_STABLE_CYC  (8),
      .MAX_RETRY        (2)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .pll_lock      (pll_lock),
      .relock_req    (relock_req),
      .pll_rst       (pll_rst),
      .design_rst    (design_rst),
      .locked        (locked),
      .fail          (fail),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt),
      .state_o       (state_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (state_o !== target && n < budget);
      chk(tag, {29'd0, state_o}, {29'd0, target});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, {29'd0, state_o}, {29'd0, S_RESET});
      chk({tag, "_pll_rst"}, {31'd0, pll_rst}, 32'd1);
      chk({tag, "_design_rst"}, {31'd0, design_rst}, 32'd1);
      chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
      chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
      chk({tag, "_retry"}, {24'd0, retry_cnt}, 32'd0);
      chk({tag, "_loss"}, {24'd0, lock_loss_cnt}, 32'd0);
   endtask

   initial begin
      sys_rst    = 1'b1;
      pll_lock   = 1'b0;
      relock_req = 1'b0;
      step(3);
      chk_reset_vals("por");

      // Bring-up: 4-cycle pll_rst, lock 3 cycles after fall, RUN 10 cycles after lock
      sys_rst = 1'b0;
      step(3);
      chk("bringup_rst_held", {31'd0, pll_rst}, 32'd1);
      step(1);
      chk("bringup_rst_fall", {31'd0, pll_rst}, 32'd0);
      chk("bringup_wait", {29'd0, state_o}, {29'd0, S_WAIT});
      step(2);
      pll_lock = 1'b1;
      step(9);
      chk("bringup_stable", {29'd0, state_o}, {29'd0, S_STABLE});
      chk("bringup_drst_hi", {31'd0, design_rst}, 32'd1);
      step(1);
      chk("bringup_drst_lo", {31'd0, design_rst}, 32'd0);
      chk("bringup_locked", {31'd0, locked}, 32'd1);
      chk("bringup_run", {29'd0, state_o}, {29'd0, S_RUN});
      chk("bringup_retry", {24'd0, retry_cnt}, 32'd0);

      // Lock loss in RUN
      pll_lock = 1'b0;
      step(2);
      chk("loss_drst_still_lo", {31'd0, design_rst}, 32'd0);
      step(1);
      chk("loss_drst_hi", {31'd0, design_rst}, 32'd1);
      chk("loss_state", {29'd0, state_o}, {29'd0, S_RESET});
      chk("loss_cnt1", {24'd0, lock_loss_cnt}, 32'd1);
      step(3);
      chk("loss_pll_rst_held", {31'd0, pll_rst}, 32'd1);
      step(1);
      chk("loss_pll_rst_fall", {31'd0, pll_rst}, 32'd0);

      for (int i = 0; i < 299; i++) begin
         pll_lock = 1'b1;
         wait_state("sat_run", S_RUN, 60);
         pll_lock = 1'b0;
         wait_state("sat_reset", S_RESET, 10);
      end
      chk("loss_saturated", {24'd0, lock_loss_cnt}, 32'd255);

      // Glitch during STABLE restarts qualification
      wait_state("glitch_wait", S_WAIT, 10);
      pll_lock = 1'b1;
      wait_state("glitch_stable", S_STABLE, 10);
      step(3);
      pll_lock = 1'b0;
      step(1);
      pll_lock = 1'b1;
      step(1);
      chk("glitch_still_stable", {29'd0, state_o}, {29'd0, S_STABLE});
      step(1);
      chk("glitch_to_wait", {29'd0, state_o}, {29'd0, S_WAIT});
      step(1);
      chk("glitch_restable", {29'd0, state_o}, {29'd0, S_STABLE});
      step(6);
      chk("glitch_not_yet_run", {31'd0, design_rst}, 32'd1);
      step(1);
      chk("glitch_run", {29'd0, state_o}, {29'd0, S_RUN});
      chk("glitch_locked", {31'd0, locked}, 32'd1);

      // Lock never returns: two timeouts then FAIL
      pll_lock = 1'b0;
      wait_state("retry_wait1", S_WAIT, 12);
      step(19);
      chk("retry_win1_end", {29'd0, state_o}, {29'd0, S_WAIT});
      step(1);
      chk("retry_to_reset", {29'd0, state_o}, {29'd0, S_RESET});
      chk("retry_cnt1", {24'd0, retry_cnt}, 32'd1);
      step(3);
      chk("retry_pulse_held", {31'd0, pll_rst}, 32'd1);
      step(1);
      chk("retry_wait2", {29'd0, state_o}, {29'd0, S_WAIT});
      step(19);
      chk("retry_win2_end", {29'd0, state_o}, {29'd0, S_WAIT});
      step(1);
      chk("fail_state", {29'd0, state_o}, {29'd0, S_FAIL});
      chk("fail_flag", {31'd0, fail}, 32'd1);
      chk("fail_pll_rst", {31'd0, pll_rst}, 32'd1);
      chk("fail_retry", {24'd0, retry_cnt}, 32'd2);
      step(10);
      chk("fail_sticky", {29'd0, state_o}, {29'd0, S_FAIL});
      relock_req = 1'b1;
      step(1);
      relock_req = 1'b0;
      chk("relock_state", {29'd0, state_o}, {29'd0, S_RESET});
      chk("relock_retry", {24'd0, retry_cnt}, 32'd0);
      chk("relock_fail", {31'd0, fail}, 32'd0);
      chk("relock_loss_kept", {24'd0, lock_loss_cnt}, 32'd255);

      // relock_req coinciding with a timeout wins
      wait_state("prio_wait1", S_WAIT, 10);
      step(20);
      chk("prio_retry1", {24'd0, retry_cnt}, 32'd1);
      wait_state("prio_wait2", S_WAIT, 10);
      step(19);
      relock_req = 1'b1;
      step(1);
      relock_req = 1'b0;
      chk("prio_state", {29'd0, state_o}, {29'd0, S_RESET});
      chk("prio_retry0", {24'd0, retry_cnt}, 32'd0);
      chk("prio_no_fail", {31'd0, fail}, 32'd0);
      step(3);
      chk("prio_hold", {29'd0, state_o}, {29'd0, S_RESET});
      step(1);
      chk("prio_wait", {29'd0, state_o}, {29'd0, S_WAIT});

      // Asynchronous reset mid-STABLE
      pll_lock = 1'b1;
      wait_state("arst_stable", S_STABLE, 10);
      step(2);
      sys_rst = 1'b1;
      #1;
      chk_reset_vals("arst");
      step(2);
      sys_rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
